// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings for the instruction fetch unit: next-PC select codes,
// fetch error causes, FSM state encoding and the NOP word.
package instr_fetch_unit_pkg;

  localparam logic [3:0] PC_SEL_BOOT   = 4'd0;
  localparam logic [3:0] PC_SEL_PLUS4  = 4'd1;
  localparam logic [3:0] PC_SEL_BRANCH = 4'd2;
  localparam logic [3:0] PC_SEL_JUMP   = 4'd3;
  localparam logic [3:0] PC_SEL_EXC    = 4'd4;
  localparam logic [3:0] PC_SEL_HOLD   = 4'd5;

  localparam logic [1:0] FETCH_ERR_NONE     = 2'd0;
  localparam logic [1:0] FETCH_ERR_BUS      = 2'd1;
  localparam logic [1:0] FETCH_ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] FETCH_ERR_MISALIGN = 2'd3;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory port of the fetch unit: master = fetch unit, slave = memory.
interface instr_fetch_unit_if;
  // Handshake: imem_req/imem_addr are held stable until a cycle with imem_gnt=1,
  // which accepts the request. Exactly one response follows, marked by a
  // single-cycle imem_rvalid; imem_rdata and imem_err are meaningful only then.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err
  );
endinterface

// File: rtl/instr_fetch_unit_next_pc_mux.sv
// Combinational next-PC selection; unused select codes keep the PC where it is.
module next_pc_mux
  import instr_fetch_unit_pkg::*;
(
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_boot_addr,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_exc_vector,
  output logic [31:0] o_next_pc
);

  always_comb begin
    o_next_pc = i_pc;
    case (i_sel)
      PC_SEL_BOOT:   o_next_pc = i_boot_addr;
      PC_SEL_PLUS4:  o_next_pc = i_pc + 32'd4;
      PC_SEL_BRANCH: o_next_pc = i_branch_target;
      PC_SEL_JUMP:   o_next_pc = i_jump_target;
      PC_SEL_EXC:    o_next_pc = i_exc_vector;
      PC_SEL_HOLD:   o_next_pc = i_pc;
      default:       o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch responder: on a controller pulse, picks the next PC, reads one word from
// instruction memory with a timeout, and reports it with a one-cycle done pulse.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = NOP_ENC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_req,
  input  logic [3:0]                pc_mux_sel,
  input  logic [31:0]               boot_addr,
  input  logic [31:0]               branch_target,
  input  logic [31:0]               jump_target,
  input  logic [31:0]               exc_vector,
  output logic                      busy,
  output logic                      fetch_done,
  output logic [31:0]               instr_out,
  output logic [31:0]               pc_out,
  output logic                      fetch_err,
  output logic [1:0]                err_cause,
  output fetch_state_e              dbg_state,
  instr_fetch_unit_if.master        imem
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  fetch_state_e  r_state;
  logic [31:0]   r_pc;
  logic [TW-1:0] r_timer;
  logic          r_drop_pending;
  logic [31:0]   r_instr;
  logic [1:0]    r_err_cause;

  logic [31:0]   w_next_pc;
  logic          w_in_flight;
  logic          w_timeout;
  logic          w_req;
  logic          w_req_gnt;

  next_pc_mux u_next_pc_mux (
    .i_sel           (pc_mux_sel),
    .i_pc            (r_pc),
    .i_boot_addr     (boot_addr),
    .i_branch_target (branch_target),
    .i_jump_target   (jump_target),
    .i_exc_vector    (exc_vector),
    .o_next_pc       (w_next_pc)
  );

  assign w_in_flight = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_timeout   = w_in_flight && (r_timer == TW'(TIMEOUT_CYCLES - 1));
  // A response still owed to an aborted fetch must drain before a new request.
  assign w_req       = (r_state == S_REQ) && !r_drop_pending;
  assign w_req_gnt   = w_req && imem.imem_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_pc           <= '0;
      r_timer        <= '0;
      r_drop_pending <= 1'b0;
      r_instr        <= '0;
      r_err_cause    <= FETCH_ERR_NONE;
    end else begin
      if (r_drop_pending && imem.imem_rvalid) r_drop_pending <= 1'b0;
      if (w_in_flight && (r_timer != TW'(TIMEOUT_CYCLES))) r_timer <= r_timer + TW'(1);

      case (r_state)
        S_IDLE: begin
          if (fetch_req) begin
            r_pc    <= w_next_pc;
            r_timer <= '0;
            if (!is_word_aligned(w_next_pc)) begin
              r_state     <= S_DONE;
              r_err_cause <= FETCH_ERR_MISALIGN;
              r_instr     <= NOP_INSTR;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // Timeout beats a same-cycle grant; the granted response is then orphaned.
          if (w_timeout) begin
            r_state     <= S_DONE;
            r_err_cause <= FETCH_ERR_TIMEOUT;
            r_instr     <= NOP_INSTR;
            if (w_req_gnt) r_drop_pending <= 1'b1;
          end else if (w_req_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            r_state <= S_DONE;
            if (imem.imem_err) begin
              r_err_cause <= FETCH_ERR_BUS;
              r_instr     <= NOP_INSTR;
            end else begin
              r_err_cause <= FETCH_ERR_NONE;
              r_instr     <= imem.imem_rdata;
            end
          end else if (w_timeout) begin
            r_state        <= S_DONE;
            r_err_cause    <= FETCH_ERR_TIMEOUT;
            r_instr        <= NOP_INSTR;
            r_drop_pending <= 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign fetch_done     = (r_state == S_DONE);
  assign fetch_err      = fetch_done && (r_err_cause != FETCH_ERR_NONE);
  assign instr_out      = r_instr;
  assign pc_out         = r_pc;
  assign err_cause      = r_err_cause;
  assign dbg_state      = r_state;
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: reactive memory model, transaction-level timing
// model for expected results, directed scenarios followed by random fetches.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int          TO  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [3:0]  pc_mux_sel = 4'd0;
  logic [31:0] boot_addr = '0, branch_target = '0, jump_target = '0, exc_vector = '0;
  logic        busy, fetch_done, fetch_err;
  logic [31:0] instr_out, pc_out;
  logic [1:0]  err_cause;
  fetch_state_e dbg_state;

  instr_fetch_unit_if m_if ();

  instr_fetch_unit #(.TIMEOUT_CYCLES(TO), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req     (fetch_req),
    .pc_mux_sel    (pc_mux_sel),
    .boot_addr     (boot_addr),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .exc_vector    (exc_vector),
    .busy          (busy),
    .fetch_done    (fetch_done),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .fetch_err     (fetch_err),
    .err_cause     (err_cause),
    .dbg_state     (dbg_state),
    .imem          (m_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard / counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- memory model ----------------
  int          cfg_g = 0, cfg_r = 1;
  logic [31:0] cfg_data = '0;
  logic        cfg_err = 1'b0;
  int          req_cnt = 0, rsp_cnt = -1, req_seen = 0, done_cnt = 0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;

  task automatic mem_step();
    logic [31:0] exp_a;
    m_if.imem_gnt    = 1'b0;
    m_if.imem_rvalid = 1'b0;
    m_if.imem_rdata  = '0;
    m_if.imem_err    = 1'b0;
    if (!rst) begin
      rsp_cnt = -1;
      req_cnt = 0;
      return;
    end
    if (rsp_cnt == 0) begin
      m_if.imem_rvalid = 1'b1;
      m_if.imem_rdata  = rsp_data;
      m_if.imem_err    = rsp_err;
      rsp_cnt = -1;
    end else if (rsp_cnt > 0) begin
      rsp_cnt--;
    end
    if (m_if.imem_req) begin
      req_seen++;
      if (req_cnt >= cfg_g) begin
        m_if.imem_gnt = 1'b1;
        exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : ~m_if.imem_addr;
        check("gnt_addr", m_if.imem_addr, exp_a);
        rsp_cnt  = cfg_r - 1;
        rsp_data = cfg_data;
        rsp_err  = cfg_err;
        req_cnt  = 0;
      end else begin
        req_cnt++;
      end
    end
  endtask

  initial begin
    m_if.imem_gnt = 1'b0; m_if.imem_rvalid = 1'b0; m_if.imem_rdata = '0; m_if.imem_err = 1'b0;
    forever begin
      @(negedge clk);
      mem_step();
      if (fetch_done) done_cnt++;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_pc = '0;
  int          stale = -1;   // cycle in which an orphaned response will arrive

  function automatic logic [31:0] ref_next(input logic [3:0] sel);
    case (sel)
      4'd0:    return boot_addr;
      4'd1:    return m_pc + 32'd4;
      4'd2:    return branch_target;
      4'd3:    return jump_target;
      4'd4:    return exc_vector;
      default: return m_pc;
    endcase
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return a;
  endfunction

  // ---------------- driver ----------------
  // Called at negedge+1; returns at negedge+1 of the cycle after fetch_done.
  task automatic do_fetch(input logic [3:0] sel, input int g, input int r,
                          input logic [31:0] data, input logic err, input logic extra);
    logic [31:0] npc, e_instr;
    logic [1:0]  e_cause;
    int t, lim, first, gc, rc, e_done, done_at, seen0, dc0, k;
    bit got;
    k = 0;
    while (busy && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    check("idle_before", 32'(busy), 32'd0);

    npc = ref_next(sel);
    m_pc = npc;
    t = cyc;
    lim = t + TO;
    seen0 = req_seen;
    dc0 = done_cnt;
    cfg_g = g; cfg_r = r; cfg_data = data; cfg_err = err; req_cnt = 0;

    if (npc[1:0] != 2'b00) begin
      e_done = t + 1; e_cause = 2'd3; e_instr = NOP;
    end else begin
      if (stale >= 0 && stale <= t) stale = -1;
      first = (stale >= 0) ? stale + 1 : t + 1;
      gc = first + g;
      if (gc > lim) begin
        e_done = lim + 1; e_cause = 2'd2; e_instr = NOP;
      end else begin
        exp_q.push_back(npc);
        rc = gc + r;
        if (gc == lim || rc > lim) begin
          e_done = lim + 1; e_cause = 2'd2; e_instr = NOP; stale = rc;
        end else begin
          e_done = rc + 1; stale = -1;
          e_cause = err ? 2'd1 : 2'd0;
          e_instr = err ? NOP : data;
        end
      end
    end

    pc_mux_sel = sel;
    fetch_req = 1'b1;
    got = 0;
    done_at = -1;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk); #1;
      fetch_req = (i == 1) && extra;
      if (fetch_done) begin
        got = 1;
        done_at = cyc;
      end
    end
    fetch_req = 1'b0;

    check("done_latency", 32'(done_at - t), 32'(e_done - t));
    check("pc_out", pc_out, npc);
    check("instr_out", instr_out, e_instr);
    check("err_cause", 32'(err_cause), 32'(e_cause));
    check("fetch_err", 32'(fetch_err), 32'(e_cause != 2'd0));
    if (npc[1:0] != 2'b00) check("no_req_misalign", 32'(req_seen - seen0), 32'd0);
    @(negedge clk); #1;
    check("done_pulse_end", 32'(fetch_done), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
    check("done_count", 32'(done_cnt - dc0), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(fetch_done), 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_cause", 32'(err_cause), 32'd0);
    check("rst_req", 32'(m_if.imem_req), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    #1 rst = 1'b1;
    @(negedge clk); #1;

    // 1: BOOT fetch at minimum latency
    boot_addr = 32'h100;
    do_fetch(4'd0, 0, 1, 32'hDEADBEEF, 1'b0, 1'b0);

    // 2: PLUS4 wraps; HOLD and an unused code keep the PC
    boot_addr = 32'hFFFF_FFFC;
    do_fetch(4'd0, 1, 2, 32'h1111_1111, 1'b0, 1'b0);
    boot_addr = 32'h4000;
    do_fetch(4'd1, 0, 1, 32'h2222_2222, 1'b0, 1'b0);
    do_fetch(4'd5, 2, 3, 32'h3333_3333, 1'b0, 1'b0);
    do_fetch(4'd9, 0, 1, 32'h4444_4444, 1'b0, 1'b0);

    // 3: misaligned jump
    jump_target = 32'h102;
    do_fetch(4'd3, 0, 1, 32'h5555_5555, 1'b0, 1'b0);

    // 4: timeout in WAIT, then the stale response holds off the next request
    branch_target = 32'h800;
    do_fetch(4'd2, 0, 10, 32'h6666_6666, 1'b0, 1'b0);
    exc_vector = 32'h900;
    do_fetch(4'd4, 0, 1, 32'h7777_7777, 1'b0, 1'b0);

    // 5: bus error with an ignored second request while busy
    do_fetch(4'd1, 1, 2, 32'h8888_8888, 1'b1, 1'b1);

    // 6: asynchronous reset while waiting for rvalid
    boot_addr = 32'h200;
    cfg_g = 0; cfg_r = 6; cfg_data = 32'h9999_9999; cfg_err = 1'b0; req_cnt = 0;
    exp_q.push_back(32'h200);
    pc_mux_sel = 4'd0;
    fetch_req = 1'b1;
    @(negedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk); #1;
    check("pre_rst_state", 32'(dbg_state), 32'(S_WAIT));
    #1 rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pc", pc_out, 32'd0);
    check("arst_instr", instr_out, 32'd0);
    check("arst_cause", 32'(err_cause), 32'd0);
    check("arst_req", 32'(m_if.imem_req), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    m_pc = '0;
    stale = -1;
    @(negedge clk); #1;
    boot_addr = 32'h300;
    do_fetch(4'd0, 0, 1, 32'hCAFE_F00D, 1'b0, 1'b0);

    // random fetches
    for (int n = 0; n < 40; n++) begin
      logic [3:0] sel;
      boot_addr = rand_addr();
      branch_target = rand_addr();
      jump_target = rand_addr();
      exc_vector = rand_addr();
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      do_fetch(sel, $urandom_range(0, 9), $urandom_range(1, 10), $urandom,
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end

    repeat (15) @(negedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
